// File: rtl/wrr_scheduler.sv
// Weighted round-robin scheduler: grants one requester at a time for up to
// its programmed weight (capped at WEIGHTLIMIT), then inserts a one-cycle gap
// and rotates priority to the channel after the last winner.
//
// Ports:
//   clk, reset     - clock; asynchronous active-high reset
//   cfg_we         - weight-table write strobe
//   cfg_addr       - channel index for the weight write (>= CHANNELS ignored)
//   cfg_wdata      - weight value to write
//   request        - per-channel level-sensitive request
//   early_release  - terminate the current grant at the next edge
//   grant          - registered one-hot (or zero) grant vector
//   grant_id       - index of the granted channel, 0 when nothing is granted
//   busy           - high while a grant is being held
module wrr_scheduler #(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned WEIGHTLIMIT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]            cfg_wdata,
    input  logic [CHANNELS-1:0]         request,
    input  logic                        early_release,
    output logic [CHANNELS-1:0]         grant,
    output logic [$clog2(CHANNELS)-1:0] grant_id,
    output logic                        busy
);

    localparam int unsigned IDW = $clog2(CHANNELS);
    localparam int unsigned CW  = $clog2(WEIGHTLIMIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CHANNELS-1:0]   grant_d;
    logic [IDW-1:0]        grant_id_d;
    logic                  busy_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         eff_q, eff_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [WIDTH-1:0]      weights_q [CHANNELS];

    logic                  pick_found;
    logic [IDW-1:0]        pick_id;
    logic [CW-1:0]         pick_eff;
    logic                  hold_exit;

    // Rotating search: first requester strictly after the last winner.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            if (!pick_found && request[IDW'((32'(ptr_q) + i) % CHANNELS)]) begin
                pick_found = 1'b1;
                pick_id    = IDW'((32'(ptr_q) + i) % CHANNELS);
            end
        end
    end

    // Effective grant length: a zero weight acts as 1, large weights are capped.
    always_comb begin
        if (weights_q[pick_id] == '0) begin
            pick_eff = CW'(1);
        end else if (32'(weights_q[pick_id]) > WEIGHTLIMIT) begin
            pick_eff = CW'(WEIGHTLIMIT);
        end else begin
            pick_eff = CW'(weights_q[pick_id]);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant;
        grant_id_d = grant_id;
        busy_d     = busy;
        cnt_d      = cnt_q;
        eff_d      = eff_q;
        ptr_d      = ptr_q;
        // Weight reached, release, or winner dropped its request: one exit either way.
        hold_exit  = (cnt_q >= eff_q) || early_release || !request[grant_id];

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = HOLD;
                    grant_d    = CHANNELS'(1) << pick_id;
                    grant_id_d = pick_id;
                    busy_d     = 1'b1;
                    cnt_d      = CW'(1);
                    eff_d      = pick_eff;
                end
            end
            HOLD: begin
                if (hold_exit) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    cnt_d      = '0;
                    ptr_d      = grant_id;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            cnt_q    <= '0;
            eff_q    <= '0;
            ptr_q    <= IDW'(CHANNELS - 1);
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            grant_id <= grant_id_d;
            busy     <= busy_d;
            cnt_q    <= cnt_d;
            eff_q    <= eff_d;
            ptr_q    <= ptr_d;
        end
    end

    // Weight table; an in-flight grant keeps its latched length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                weights_q[i] <= WIDTH'(1);
            end
        end else if (cfg_we && (32'(cfg_addr) < CHANNELS)) begin
            weights_q[cfg_addr] <= cfg_wdata;
        end
    end

endmodule
